// File: rtl/serial_byte_reader_if.sv
// Bus between a serial line front end and the parallel word consumer.
// master drives start and the raw serial lines; slave returns the captured word.
`timescale 1ns/1ps
interface serial_byte_reader_if #(
    parameter int BUF_SIZE = 8
);
    logic                start;
    logic                sig;
    logic                data_in;
    logic                edge_sig;
    logic [BUF_SIZE-1:0] data_out;
    logic                done_sig;

    modport master (
        output start, sig, data_in,
        input  edge_sig, data_out, done_sig
    );

    modport slave (
        input  start, sig, data_in,
        output edge_sig, data_out, done_sig
    );
endinterface

// File: rtl/serial_byte_reader.sv
// Captures an MSB-first serial word on a synchronised serial clock edge
// and presents the last completed word in parallel.
`timescale 1ns/1ps
module serial_byte_reader #(
    parameter int BUF_SIZE  = 8,
    parameter bit FALL_EDGE = 1'b0
) (
    input logic                  sys_clk,
    input logic                  rst,
    serial_byte_reader_if.slave  bus
);
    localparam int CW = $clog2(BUF_SIZE) + 1;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t              state_q;
    logic                sig_s1_q;
    logic                sig_s2_q;
    logic                sig_prev_q;
    logic                din_s1_q;
    logic                din_s2_q;
    logic                edge_q;
    logic                edge_d;
    logic                done_q;
    logic [BUF_SIZE-1:0] shift_q;
    logic [BUF_SIZE-1:0] shift_d;
    logic [BUF_SIZE-1:0] data_q;
    logic [CW-1:0]       cnt_q;

    // Data uses the same two-flop depth as the clock so bits stay aligned.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            sig_s1_q   <= 1'b0;
            sig_s2_q   <= 1'b0;
            sig_prev_q <= 1'b0;
            din_s1_q   <= 1'b0;
            din_s2_q   <= 1'b0;
            edge_q     <= 1'b0;
        end else begin
            sig_s1_q   <= bus.sig;
            sig_s2_q   <= sig_s1_q;
            sig_prev_q <= sig_s2_q;
            din_s1_q   <= bus.data_in;
            din_s2_q   <= din_s1_q;
            edge_q     <= edge_d;
        end
    end

    assign edge_d = FALL_EDGE ? (sig_prev_q & ~sig_s2_q)
                              : (~sig_prev_q & sig_s2_q);

    assign shift_d = {shift_q[BUF_SIZE-2:0], din_s2_q};

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        shift_q <= '0;
                        cnt_q   <= '0;
                        done_q  <= 1'b0;
                        state_q <= READ;
                    end
                end
                READ: begin
                    if (edge_q) begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CW'(BUF_SIZE - 1)) begin
                            data_q  <= shift_d;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.edge_sig = edge_q;
    assign bus.data_out = data_q;
    assign bus.done_sig = done_q;
endmodule

// File: tb/tb_serial_byte_reader.sv
// Bench for serial_byte_reader: directed scenarios plus random words,
// checked against a word-level model of the last completed capture.
`timescale 1ns/1ps
module tb_serial_byte_reader;
    logic sys_clk = 1'b0;
    logic rst = 1'b1;

    always #41.667 sys_clk = ~sys_clk;

    serial_byte_reader_if #(.BUF_SIZE(8)) ifa ();
    serial_byte_reader_if #(.BUF_SIZE(8)) ifb ();

    serial_byte_reader #(
        .BUF_SIZE(8),
        .FALL_EDGE(1'b0)
    ) u_rise (
        .sys_clk(sys_clk),
        .rst(rst),
        .bus(ifa.slave)
    );

    serial_byte_reader #(
        .BUF_SIZE(8),
        .FALL_EDGE(1'b1)
    ) u_fall (
        .sys_clk(sys_clk),
        .rst(rst),
        .bus(ifb.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int edges_a = 0;
    int edges_b = 0;
    logic [7:0] exp_a;
    logic [7:0] exp_b;

    always @(posedge sys_clk) begin
        cyc++;
        if (ifa.edge_sig === 1'b1) edges_a++;
        if (ifb.edge_sig === 1'b1) edges_b++;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_line(input bit fe, input logic s, input logic d);
        if (fe) begin
            ifb.sig = s;
            ifb.data_in = d;
        end else begin
            ifa.sig = s;
            ifa.data_in = d;
        end
    endtask

    task automatic set_start(input bit fe, input logic v);
        if (fe) ifb.start = v;
        else ifa.start = v;
    endtask

    function automatic logic get_edge(input bit fe);
        return fe ? ifb.edge_sig : ifa.edge_sig;
    endfunction

    function automatic logic get_done(input bit fe);
        return fe ? ifb.done_sig : ifa.done_sig;
    endfunction

    function automatic logic [7:0] get_data(input bit fe);
        return fe ? ifb.data_out : ifa.data_out;
    endfunction

    task automatic do_start(input bit fe);
        @(negedge sys_clk);
        set_start(fe, 1'b1);
        @(posedge sys_clk);
        #1;
        check("busy_after_start", 32'(get_done(fe)), 32'd0);
        @(negedge sys_clk);
        set_start(fe, 1'b0);
    endtask

    // One serial bit per 8 cycles; data changes on the inactive transition.
    task automatic send_word(input bit fe, input logic [7:0] w,
                             input int ign, input bit chk);
        int t0;
        int n;
        for (int b = 0; b < 8; b++) begin
            set_line(fe, fe, w[7-b]);
            if (b == ign) set_start(fe, 1'b1);
            @(negedge sys_clk);
            set_start(fe, 1'b0);
            repeat (3) @(negedge sys_clk);
            set_line(fe, !fe, w[7-b]);
            t0 = cyc;
            n = 0;
            if (chk) begin
                do begin
                    @(posedge sys_clk);
                    #1;
                    n++;
                end while (get_edge(fe) !== 1'b1 && n < 8);
                check(fe ? "edge_lat_fall" : "edge_lat_rise", 32'(n), 32'd3);
                if (b == 7) begin
                    while (get_done(fe) !== 1'b1 && n < 10) begin
                        @(posedge sys_clk);
                        #1;
                        n++;
                    end
                    check("done_lat", 32'(n >= 3 && n <= 4), 32'd1);
                end
            end
            do @(negedge sys_clk); while (cyc < t0 + 4);
        end
    endtask

    task automatic toggle(input bit fe, input int n);
        for (int k = 0; k < n; k++) begin
            set_line(fe, fe, 1'($urandom));
            repeat (4) @(negedge sys_clk);
            set_line(fe, !fe, 1'($urandom));
            repeat (4) @(negedge sys_clk);
        end
        repeat (5) @(negedge sys_clk);
    endtask

    task automatic word_test(input bit fe, input logic [7:0] w,
                             input int ign, input string tag);
        int base;
        do_start(fe);
        base = fe ? edges_b : edges_a;
        send_word(fe, w, ign, 1'b1);
        if (fe) exp_b = w;
        else exp_a = w;
        check({tag, "_data"}, 32'(get_data(fe)), 32'(fe ? exp_b : exp_a));
        check({tag, "_done"}, 32'(get_done(fe)), 32'd1);
        check({tag, "_edges"}, 32'((fe ? edges_b : edges_a) - base), 32'd8);
    endtask

    initial begin
        #(100000 * 84);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic [7:0] w;
        exp_a = 8'h00;
        exp_b = 8'h00;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        set_line(1'b0, 1'b0, 1'b0);
        set_line(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge sys_clk);
        check("rst_done_a", 32'(ifa.done_sig), 32'd1);
        check("rst_data_a", 32'(ifa.data_out), 32'd0);
        check("rst_edge_a", 32'(ifa.edge_sig), 32'd0);
        check("rst_done_b", 32'(ifb.done_sig), 32'd1);
        check("rst_data_b", 32'(ifb.data_out), 32'd0);
        check("rst_edge_b", 32'(ifb.edge_sig), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge sys_clk);

        word_test(1'b0, 8'h3A, -1, "w3a");

        // Reset part-way through 0x71 must abort and stay aborted.
        toggle(1'b0, 2);
        do_start(1'b0);
        fork
            send_word(1'b0, 8'h71, -1, 1'b0);
            begin
                repeat (40) @(posedge sys_clk);
                @(negedge sys_clk);
                rst = 1'b1;
                #1;
                exp_a = 8'h00;
                exp_b = 8'h00;
                check("abort_done", 32'(ifa.done_sig), 32'd1);
                check("abort_data", 32'(ifa.data_out), 32'(exp_a));
                repeat (2) @(negedge sys_clk);
                rst = 1'b0;
            end
        join
        repeat (6) @(negedge sys_clk);
        check("post_abort_data", 32'(ifa.data_out), 32'(exp_a));
        check("post_abort_done", 32'(ifa.done_sig), 32'd1);
        check("post_abort_data_b", 32'(ifb.data_out), 32'(exp_b));

        word_test(1'b0, 8'hF0, -1, "wf0");
        toggle(1'b0, 3);
        check("hold_f0_data", 32'(ifa.data_out), 32'(exp_a));
        check("hold_f0_done", 32'(ifa.done_sig), 32'd1);

        word_test(1'b0, 8'hA5, 3, "wa5");

        word_test(1'b1, 8'h3C, -1, "w3c_fall");

        // Start landing in the same cycle as an edge pulse.
        toggle(1'b0, 2);
        check("idle_edges_hold", 32'(ifa.data_out), 32'(exp_a));
        set_line(1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge sys_clk);
        set_line(1'b0, 1'b1, 1'b1);
        n = 0;
        do begin
            @(posedge sys_clk);
            #1;
            n++;
        end while (ifa.edge_sig !== 1'b1 && n < 8);
        check("coinc_edge_seen", 32'(ifa.edge_sig), 32'd1);
        ifa.start = 1'b1;
        @(posedge sys_clk);
        #1;
        check("coinc_busy", 32'(ifa.done_sig), 32'd0);
        @(negedge sys_clk);
        ifa.start = 1'b0;
        base = edges_a;
        repeat (3) @(negedge sys_clk);
        send_word(1'b0, 8'h81, -1, 1'b1);
        exp_a = 8'h81;
        check("w81_data", 32'(ifa.data_out), 32'(exp_a));
        check("w81_edges", 32'(edges_a - base), 32'd8);

        for (int k = 0; k < 10; k++) begin
            bit fe;
            fe = 1'($urandom);
            w = 8'($urandom);
            toggle(fe, $urandom_range(0, 2));
            word_test(fe, w, $urandom_range(0, 9), "rnd");
            check("rnd_other_hold", 32'(get_data(!fe)),
                  32'(fe ? exp_a : exp_b));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_byte_reader.md
Name: serial_byte_reader

Overview:
- Captures a fixed-length, MSB-first serial word clocked by a slow external serial clock, and presents it as a parallel word.
- The block synchronises the serial clock into the system clock domain and detects its active edge internally, then shifts in one bit per detected edge after a start command.
- Sits between a sniffed or forwarded serial bus line and the parallel packet-processing logic.

Parameters:
- BUF_SIZE, 8, number of bits per captured word (≥2).
- FALL_EDGE, 0, 0 = sample on rising edge of serial clock; 1 = sample on falling edge.

Ports:
- sys_clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a capture of BUF_SIZE bits.
- sig  input  1  raw external serial clock; asynchronous to sys_clk.
- data_in  input  1  raw serial data; asynchronous; stable around the active sig edge.
- edge_sig  output  1  one-cycle pulse per detected active edge of sig (debug/reuse).
- data_out  output  BUF_SIZE  last completed captured word; bit BUF_SIZE-1 = first bit received.
- done_sig  output  1  high = idle/ready (word valid); low = capture in progress.

Behaviour:
- Reset (async, rst=1) values:
  - sync flops, edge history, shift register and bit counter = 0.
  - data_out = 0; done_sig = 1; edge_sig = 0; state IDLE.
- Synchronisation:
  - sig and data_in each pass through an identical 2-flop synchroniser, so bits stay aligned with their clock.
- Edge detection:
  - A third register holds the previous synced sig.
  - edge_sig = registered pulse, high for exactly one sys_clk cycle.
  - FALL_EDGE=0: high when synced sig goes 0→1. FALL_EDGE=1: high when it goes 1→0.
  - Latency from a sig transition to edge_sig high: 3 sys_clk edges.
  - The bit sampled is the synced data_in in the same cycle edge_sig is high.
- State machine:
  - IDLE (done_sig=1):
    - start=1 → clear counter and shift register; done_sig<=0; go to READ.
    - edge_sig ignored, including in the same cycle as start. The capture counts only edges after the start cycle.
    - data_out held.
  - READ (done_sig=0):
    - On each edge_sig pulse: shift <= {shift[BUF_SIZE-2:0], din_sync}; counter++.
    - start ignored in READ.
    - On the pulse where counter==BUF_SIZE-1, in that same clock edge:
      - data_out <= {shift[BUF_SIZE-2:0], din_sync}; done_sig <= 1; state IDLE.
    - data_out is not updated during partial capture.
- Counter width = clog2(BUF_SIZE)+1 bits.
- Serial clock period must be ≥ 6 sys_clk cycles (≥3 high, ≥3 low); faster input is unsupported.
- Reset mid-capture aborts immediately:
  - Partial bits are discarded, data_out=0, done_sig=1.
  - Any remaining serial edges are ignored until the next start.
- sig high when rst releases yields one spurious edge_sig pulse (FALL_EDGE=0); this is harmless in IDLE.
- No other outputs or flags.

Test Plan:
- Clocks: sys_clk 12 MHz; serial clock period 8 sys_clk cycles; data changes on the falling sig edge; default parameters.
- Reset, then start, then send 0x3A MSB-first → done_sig low the cycle after start; high 3–4 cycles after the 8th rising sig edge; data_out=0x3A; edge_sig pulsed exactly 8 times.
- Idle gap, then start, then send 0x71; assert rst about 3.3 µs after start, mid-word → done_sig=1 and data_out=0x00 immediately; the remaining bits of 0x71 cause no change.
- Start, then send 0xF0 → data_out=0xF0, done_sig=1; data_out stays 0xF0 through later idle sig toggling with no start.
- During a capture of 0xA5, pulse start again after bit 3 → ignored; data_out=0xA5 after 8 edges.
- FALL_EDGE=1 with data changing on the rising sig edge; send 0x3C → data_out=0x3C; edge_sig aligned to sig falling edges.
- Sig edges with no start, and a start coincident with an edge_sig pulse → no bit counted in that cycle; a following 8-bit word 0x81 is captured correctly.
